alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared combinational ALU. A request seen
//   in IDLE is granted and its operands and opcode are captured. The captured
//   values drive the ALU during EXEC. The ALU output is registered on the
//   EXEC->DONE edge, and DONE pulses the owner's done line. Simultaneous
//   requests are resolved round robin.
//
// Ports
//   CLK, RST                 clock; synchronous active-high reset
//   req0/req1                operation request, held until gnt
//   op1_0/op2_0/oprn_0       operands and opcode of requester 0
//   op1_1/op2_1/oprn_1       operands and opcode of requester 1
//   gnt0/gnt1                accept pulse (high for the EXEC cycle)
//   done0/done1              completion pulse (high for the DONE cycle)
//   result                   registered ALU result, shared by both requesters
//   err                      unsupported opcode, valid with done0/done1
//   busy                     high whenever the FSM is not IDLE
//   alu_op1/alu_op2/alu_oprn operands and opcode driven to the shared ALU
//   alu_result               combinational ALU output
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] op1_0,
    input  logic [DATA_WIDTH-1:0] op1_1,
    input  logic [DATA_WIDTH-1:0] op2_0,
    input  logic [DATA_WIDTH-1:0] op2_1,
    input  logic [OPRN_WIDTH-1:0] oprn_0,
    input  logic [OPRN_WIDTH-1:0] oprn_1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] cap_op1;
    logic [DATA_WIDTH-1:0] cap_op2;
    logic [OPRN_WIDTH-1:0] cap_oprn;
    logic                  cap_valid;  // captured opcode is in 0x01..0x09
    logic                  owner;      // 0: requester 0 owns the operation
    logic                  last_gnt1;  // 1: requester 1 was granted last

    logic                  any_req;
    logic                  win1;
    logic [OPRN_WIDTH-1:0] win_oprn;

    function automatic logic oprn_supported(input logic [OPRN_WIDTH-1:0] code);
        return (code >= OPRN_WIDTH'(1)) && (code <= OPRN_WIDTH'(9));
    endfunction

    // Requester 1 wins when it asks alone, or when both ask and requester 0
    // was served last. last_gnt1 comes out of reset set, so requester 0 wins
    // the first tie.
    assign any_req  = req0 || req1;
    assign win1     = req1 && (!req0 || !last_gnt1);
    assign win_oprn = win1 ? oprn_1 : oprn_0;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default is assigned before the case. Every path then writes
    // state_nxt, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers, arbitration pointer and the result/err registers.
    // RST clears the result, so an aborted operation leaves result at 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_op1   <= '0;
            cap_op2   <= '0;
            cap_oprn  <= '0;
            cap_valid <= 1'b0;
            owner     <= 1'b0;
            last_gnt1 <= 1'b1;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                cap_op1   <= win1 ? op1_1 : op1_0;
                cap_op2   <= win1 ? op2_1 : op2_0;
                cap_oprn  <= win_oprn;
                cap_valid <= oprn_supported(win_oprn);
                owner     <= win1;
                last_gnt1 <= win1;
            end
            if (state == EXEC) begin
                result <= cap_valid ? alu_result : '0;
                err    <= !cap_valid;
            end
        end
    end

    // Every output below is decoded from registered state. A change on
    // req*/op*/oprn* after the grant cannot reach the ALU or the handshakes.
    assign busy  = (state != IDLE);
    assign gnt0  = (state == EXEC) && !owner;
    assign gnt1  = (state == EXEC) &&  owner;
    assign done0 = (state == DONE) && !owner;
    assign done1 = (state == DONE) &&  owner;

    // The ALU bus is zero outside EXEC. An unsupported opcode is presented as 0.
    assign alu_op1  = (state == EXEC) ? cap_op1 : '0;
    assign alu_op2  = (state == EXEC) ? cap_op2 : '0;
    assign alu_oprn = (state == EXEC && cap_valid) ? cap_oprn : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. It provides the external shared ALU.
//   Opcode 0 returns a nonzero junk value, so a result that is not forced to
//   zero shows up. The scenario tasks run in sequence and carry hand-computed
//   expected values.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 6;

    logic          CLK;
    logic          RST;
    logic          req0, req1;
    logic [DW-1:0] op1_0, op1_1, op2_0, op2_1;
    logic [OW-1:0] oprn_0, oprn_1;
    logic          gnt0, gnt1, done0, done1, err, busy;
    logic [DW-1:0] result, alu_op1, alu_op2, alu_result;
    logic [OW-1:0] alu_oprn;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1),
        .op1_0(op1_0), .op1_1(op1_1), .op2_0(op2_0), .op2_1(op2_1),
        .oprn_0(oprn_0), .oprn_1(oprn_1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
        .alu_result(alu_result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared combinational ALU.
    always_comb begin
        case (alu_oprn)
            6'h01:   alu_result = alu_op1 + alu_op2;
            6'h02:   alu_result = alu_op1 - alu_op2;
            6'h03:   alu_result = alu_op1 * alu_op2;
            6'h04:   alu_result = alu_op1 >> alu_op2;
            6'h05:   alu_result = alu_op1 << alu_op2;
            6'h06:   alu_result = alu_op1 & alu_op2;
            6'h07:   alu_result = alu_op1 | alu_op2;
            6'h08:   alu_result = ~(alu_op1 | alu_op2);
            6'h09:   alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {gnt0, gnt1, done0, done1}); end
        n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %0h want 0", result); end
        n_cmp++; if ({alu_op1, alu_op2, alu_oprn} !== '0) begin n_bad++; $display("FAIL reset_alu_bus: got %0h/%0h/%0h want 0", alu_op1, alu_op2, alu_oprn); end
        RST = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        op1_0 = 32'd15; op2_0 = 32'd3; oprn_0 = 6'h01; req0 = 1'b1;
        tick();  // E0: request accepted
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL single_gnt: got %b want 10", {gnt0, gnt1}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if ({alu_op1, alu_op2, alu_oprn} !== {32'd15, 32'd3, 6'h01}) begin n_bad++; $display("FAIL single_alu_bus: got %0d/%0d/%0h want 15/3/1", alu_op1, alu_op2, alu_oprn); end
        req0 = 1'b0;
        tick();  // E1: result registered
        n_cmp++; if ({gnt0, done0, done1} !== 3'b010) begin n_bad++; $display("FAIL single_done: got %b want 010", {gnt0, done0, done1}); end
        n_cmp++; if (result !== 32'd18) begin n_bad++; $display("FAIL single_result: got %0d want 18", result); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
        tick();  // E2: back to IDLE
        n_cmp++; if ({done0, busy} !== 2'b00) begin n_bad++; $display("FAIL single_idle: got %b want 00", {done0, busy}); end
        n_cmp++; if (result !== 32'd18) begin n_bad++; $display("FAIL single_result_hold: got %0d want 18", result); end
    endtask

    task automatic test_contention();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        op1_0 = 32'd3;  op2_0 = 32'd3; oprn_0 = 6'h03;
        op1_1 = 32'd15; op2_1 = 32'd5; oprn_1 = 6'h02;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL cont_first_gnt: got %b want 10", {gnt0, gnt1}); end
        req0 = 1'b0;
        tick();
        n_cmp++; if ({done0, done1, gnt1} !== 3'b100) begin n_bad++; $display("FAIL cont_first_done: got %b want 100", {done0, done1, gnt1}); end
        n_cmp++; if (result !== 32'd9) begin n_bad++; $display("FAIL cont_first_result: got %0d want 9", result); end
        tick();  // IDLE; req1 still high and sampled at the next edge
        n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin n_bad++; $display("FAIL cont_gap: got %b want 0000", {gnt0, gnt1, done0, done1}); end
        tick();
        n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL cont_second_gnt: got %b want 01", {gnt0, gnt1}); end
        req1 = 1'b0;
        tick();
        n_cmp++; if ({done0, done1} !== 2'b01) begin n_bad++; $display("FAIL cont_second_done: got %b want 01", {done0, done1}); end
        n_cmp++; if (result !== 32'd10) begin n_bad++; $display("FAIL cont_second_result: got %0d want 10", result); end
        tick();
    endtask

    // Both requests held continuously. Requester 1 was served last, so the
    // grants go 0,1,0,1,0,1.
    task automatic test_fairness();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_res;
        op1_0 = 32'd1; op2_0 = 32'd1; oprn_0 = 6'h01;  // 1+1 = 2
        op1_1 = 32'd5; op2_1 = 32'd2; oprn_1 = 6'h02;  // 5-2 = 3
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int k = 0;
            while (!(gnt0 || gnt1) && k < 5) begin
                tick();
                k++;
            end
            n_cmp++; if (k >= 5) begin n_bad++; $display("FAIL fair_timeout op%0d: no grant after %0d cycles want <5", i, k); end
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_res = (i % 2 == 0) ? 32'd2 : 32'd3;
            n_cmp++; if ({gnt0, gnt1} !== exp_gnt) begin n_bad++; $display("FAIL fair_gnt op%0d: got %b want %b", i, {gnt0, gnt1}, exp_gnt); end
            tick();
            n_cmp++; if ({done0, done1} !== exp_gnt || result !== exp_res) begin n_bad++; $display("FAIL fair_done op%0d: got %b/%0d want %b/%0d", i, {done0, done1}, result, exp_gnt, exp_res); end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_invalid();
        op1_1 = 32'd8; op2_1 = 32'd1; oprn_1 = 6'h0A; req1 = 1'b1;
        tick();
        n_cmp++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL inv_gnt1: got %b want 1", gnt1); end
        n_cmp++; if (alu_oprn !== 6'h00) begin n_bad++; $display("FAIL inv_alu_oprn: got %0h want 0", alu_oprn); end
        req1 = 1'b0;
        tick();
        n_cmp++; if ({done1, err} !== 2'b11) begin n_bad++; $display("FAIL inv_done_err: got %b want 11", {done1, err}); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL inv_result: got %0h want 0", result); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err_hold: got %b want 1", err); end
        oprn_1 = 6'h04; req1 = 1'b1;  // 8 >> 1
        tick();
        req1 = 1'b0;
        tick();
        n_cmp++; if ({done1, err} !== 2'b10) begin n_bad++; $display("FAIL inv_next_done_err: got %b want 10", {done1, err}); end
        n_cmp++; if (result !== 32'd4) begin n_bad++; $display("FAIL inv_next_result: got %0d want 4", result); end
        tick();
    endtask

    task automatic test_isolation();
        op1_0 = 32'd1; op2_0 = 32'd4; oprn_0 = 6'h05; req0 = 1'b1;  // 1 << 4
        tick();
        op1_0 = 32'hFFFF; oprn_0 = 6'h06; req0 = 1'b0;
        #2;
        n_cmp++; if ({alu_op1, alu_oprn} !== {32'd1, 6'h05}) begin n_bad++; $display("FAIL iso_alu_bus: got %0h/%0h want 1/5", alu_op1, alu_oprn); end
        tick();
        n_cmp++; if ({done0, result} !== {1'b1, 32'd16}) begin n_bad++; $display("FAIL iso_result: got %b/%0d want 1/16", done0, result); end
        tick();
    endtask

    // Requester 0 was served last. Without the reset, a tie would now go to 1.
    task automatic test_reset_mid();
        op1_0 = 32'd2; op2_0 = 32'd2; oprn_0 = 6'h01;
        op1_1 = 32'd7; op2_1 = 32'd1; oprn_1 = 6'h01;
        req0 = 1'b1;
        tick();
        n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt0: got %b want 1", gnt0); end
        RST = 1'b1; req1 = 1'b1;  // the request at the reset edge is ignored
        tick();
        n_cmp++; if ({done0, done1, gnt0, gnt1, busy} !== 5'b00000) begin n_bad++; $display("FAIL rmid_abort: got %b want 00000", {done0, done1, gnt0, gnt1, busy}); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL rmid_result: got %0d want 0", result); end
        RST = 1'b0;
        tick();
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL rmid_tie: got %b want 10", {gnt0, gnt1}); end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        n_cmp++; if ({done0, result} !== {1'b1, 32'd4}) begin n_bad++; $display("FAIL rmid_after: got %b/%0d want 1/4", done0, result); end
        tick();
    endtask

    initial begin
        RST = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op1_0 = '0; op1_1 = '0; op2_0 = '0; op2_1 = '0;
        oprn_0 = '0; oprn_1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_invalid();
        test_isolation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
